// File: rtl/spi_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : spi_responder_if
//  Description : Bundles the SPI pins and the local mmio-style handshake of
//                the SPI responder.
//                slave  modport : the responder (drives MISO, RX head, flags)
//                master modport : the environment (drives SCK/CS/MOSI,
//                                 rd/wr/din, status_clr)
//  Signals     : spi_sck, spi_cs, spi_mosi     SPI master pins
//                spi_miso, spi_miso_oe         SPI responder pins
//                spi_rd, spi_dout, spi_data_avail      RX FIFO side
//                spi_wr, spi_din, spi_buffer_empty,
//                spi_buffer_full                        TX FIFO side
//                status, status_clr            sticky error flags
//  Revision    : 1.0  initial release
// ============================================================================
interface spi_responder_if;
    logic       spi_sck;
    logic       spi_cs;
    logic       spi_mosi;
    logic       spi_miso;
    logic       spi_miso_oe;
    logic       spi_rd;
    logic [7:0] spi_dout;
    logic       spi_data_avail;
    logic       spi_wr;
    logic [7:0] spi_din;
    logic       spi_buffer_empty;
    logic       spi_buffer_full;
    logic [2:0] status;
    logic       status_clr;

    modport slave (
        input  spi_sck, spi_cs, spi_mosi, spi_rd, spi_wr, spi_din, status_clr,
        output spi_miso, spi_miso_oe, spi_dout, spi_data_avail,
               spi_buffer_empty, spi_buffer_full, status
    );

    modport master (
        output spi_sck, spi_cs, spi_mosi, spi_rd, spi_wr, spi_din, status_clr,
        input  spi_miso, spi_miso_oe, spi_dout, spi_data_avail,
               spi_buffer_empty, spi_buffer_full, status
    );
endinterface
`default_nettype wire

// File: rtl/spi_responder.sv
`default_nettype none
// ============================================================================
//  Module      : spi_responder
//  Description : SPI mode-0 responder, MSB first, 8-bit frames. SCK/CS/MOSI
//                are oversampled in the clk domain. MOSI bytes land in an RX
//                FIFO (first-word-fall-through), MISO bytes come from a TX
//                FIFO, FILL is sent when the TX FIFO is empty.
//  Ports       : clk   system clock (>= 8x SCK)
//                Rst   synchronous active-high reset
//                spi   spi_responder_if.slave (SPI pins, rd/wr/din/dout,
//                      avail/empty/full, status {abort, underrun, overrun},
//                      status_clr)
//  Revision    : 1.0  initial release
// ============================================================================
module spi_responder #(
    parameter int         DEPTH       = 8,
    parameter logic [7:0] FILL        = 8'hFF,
    parameter int         SYNC_STAGES = 2
) (
    input  wire            clk,
    input  wire            Rst,
    spi_responder_if.slave spi
);

    localparam int         c_AW       = $clog2(DEPTH);
    localparam logic [2:0] c_LAST_BIT = 3'd7;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronisers and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sck_d;
    logic                   r_cs_d;

    always_ff @(posedge clk) begin
        if (Rst) begin
            r_sck_sync  <= '0;
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
            r_sck_d     <= 1'b0;
            r_cs_d      <= 1'b1;
        end else begin
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0],  spi.spi_sck};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0],   spi.spi_cs};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi.spi_mosi};
            r_sck_d     <= r_sck_sync[SYNC_STAGES-1];
            r_cs_d      <= r_cs_sync[SYNC_STAGES-1];
        end
    end

    logic w_sck_s, w_cs_s, w_mosi_s;
    logic w_sck_rise, w_sck_fall, w_cs_fall, w_cs_rise;

    assign w_sck_s    = r_sck_sync[SYNC_STAGES-1];
    assign w_cs_s     = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi_s   = r_mosi_sync[SYNC_STAGES-1];
    assign w_sck_rise =  w_sck_s & ~r_sck_d;
    assign w_sck_fall = ~w_sck_s &  r_sck_d;
    assign w_cs_fall  = ~w_cs_s  &  r_cs_d;
    assign w_cs_rise  =  w_cs_s  & ~r_cs_d;

    // ------------------------------------------------------------------
    // FIFO storage and pointers (one extra pointer bit for full/empty)
    // ------------------------------------------------------------------
    logic [7:0]  r_rx_mem [DEPTH];
    logic [7:0]  r_tx_mem [DEPTH];
    logic [c_AW:0] r_rx_wptr, r_rx_rptr, r_tx_wptr, r_tx_rptr;

    logic w_rx_empty, w_rx_full, w_tx_empty, w_tx_full;
    logic w_rx_pop_ok, w_rx_push, w_tx_pop, w_tx_push_ok;
    logic [7:0] w_rx_byte;
    logic [7:0] w_tx_head;

    assign w_rx_empty = (r_rx_wptr == r_rx_rptr);
    assign w_rx_full  = (r_rx_wptr[c_AW] != r_rx_rptr[c_AW]) &&
                        (r_rx_wptr[c_AW-1:0] == r_rx_rptr[c_AW-1:0]);
    assign w_tx_empty = (r_tx_wptr == r_tx_rptr);
    assign w_tx_full  = (r_tx_wptr[c_AW] != r_tx_rptr[c_AW]) &&
                        (r_tx_wptr[c_AW-1:0] == r_tx_rptr[c_AW-1:0]);

    assign w_rx_pop_ok  = spi.spi_rd & ~w_rx_empty;
    // A pop from the SPI side frees a slot on the same cycle.
    assign w_tx_push_ok = spi.spi_wr & (~w_tx_full | w_tx_pop);
    assign w_tx_head    = r_tx_mem[r_tx_rptr[c_AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_rx_push)
            r_rx_mem[r_rx_wptr[c_AW-1:0]] <= w_rx_byte;
        if (w_tx_push_ok)
            r_tx_mem[r_tx_wptr[c_AW-1:0]] <= spi.spi_din;
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            r_rx_wptr <= '0;
            r_rx_rptr <= '0;
            r_tx_wptr <= '0;
            r_tx_rptr <= '0;
        end else begin
            if (w_rx_push)    r_rx_wptr <= r_rx_wptr + 1'b1;
            if (w_rx_pop_ok)  r_rx_rptr <= r_rx_rptr + 1'b1;
            if (w_tx_push_ok) r_tx_wptr <= r_tx_wptr + 1'b1;
            if (w_tx_pop)     r_tx_rptr <= r_tx_rptr + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Frame state machine and shift registers
    // ------------------------------------------------------------------
    state_t     r_state, w_state_nxt;
    logic [2:0] r_bit_cnt, w_bit_cnt_nxt;
    logic [7:0] r_tx_shift, w_tx_shift_nxt;
    logic [6:0] r_rx_shift, w_rx_shift_nxt;
    logic [2:0] r_status, w_status_set;

    // Only the low seven bits of the RX shifter are ever needed: the eighth
    // bit of a byte is taken straight from mosi_s when it is pushed.
    assign w_rx_byte = {r_rx_shift, w_mosi_s};

    always_ff @(posedge clk) begin
        if (Rst) begin
            r_state    <= ST_IDLE;
            r_bit_cnt  <= 3'd0;
            r_tx_shift <= FILL;
            r_rx_shift <= 7'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_tx_shift <= w_tx_shift_nxt;
            r_rx_shift <= w_rx_shift_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_tx_shift_nxt = r_tx_shift;
        w_rx_shift_nxt = r_rx_shift;
        w_tx_pop       = 1'b0;
        w_rx_push      = 1'b0;
        w_status_set   = 3'b000;

        case (r_state)
            ST_IDLE: begin
                if (w_cs_fall) begin
                    w_state_nxt   = ST_ACTIVE;
                    w_bit_cnt_nxt = 3'd0;
                    if (!w_tx_empty) begin
                        w_tx_shift_nxt = w_tx_head;
                        w_tx_pop       = 1'b1;
                    end else begin
                        w_tx_shift_nxt  = FILL;
                        w_status_set[1] = 1'b1;
                    end
                end
            end

            ST_ACTIVE: begin
                if (w_cs_rise) begin
                    w_state_nxt   = ST_IDLE;
                    w_bit_cnt_nxt = 3'd0;
                    if (r_bit_cnt != 3'd0)
                        w_status_set[2] = 1'b1;
                end else if (w_sck_rise) begin
                    w_rx_shift_nxt = w_rx_byte[6:0];
                    w_bit_cnt_nxt  = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == c_LAST_BIT) begin
                        w_bit_cnt_nxt = 3'd0;
                        // A local pop on the same cycle makes room.
                        if (w_rx_full && !w_rx_pop_ok)
                            w_status_set[0] = 1'b1;
                        else
                            w_rx_push = 1'b1;
                    end
                end else if (w_sck_fall) begin
                    if (r_bit_cnt == 3'd0) begin
                        // Byte boundary: present the next byte on MISO.
                        if (!w_tx_empty) begin
                            w_tx_shift_nxt = w_tx_head;
                            w_tx_pop       = 1'b1;
                        end else begin
                            w_tx_shift_nxt  = FILL;
                            w_status_set[1] = 1'b1;
                        end
                    end else begin
                        w_tx_shift_nxt = {r_tx_shift[6:0], 1'b0};
                    end
                end
            end

            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Sticky status; a set on the clearing cycle survives.
    always_ff @(posedge clk) begin
        if (Rst)
            r_status <= 3'b000;
        else
            r_status <= (spi.status_clr ? 3'b000 : r_status) | w_status_set;
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign spi.spi_miso         = r_tx_shift[7];
    assign spi.spi_miso_oe      = ~w_cs_s;
    assign spi.spi_dout         = w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rptr[c_AW-1:0]];
    assign spi.spi_data_avail   = ~w_rx_empty;
    assign spi.spi_buffer_empty = w_tx_empty;
    assign spi.spi_buffer_full  = w_tx_full;
    assign spi.status           = r_status;

endmodule
`default_nettype wire
